ascon_obi_mgr_arb: RTL

- Shares one OBI manager port between the ASCON DMA engines: auth write, bdo write, cmd read, key read and bdi read.
- Round-robin arbitration of requests onto the single port.
- Records the grant order in an ordering FIFO and steers each in-order response back to the requester that issued it.
- Sits between the ASCON wrapper's manager array and one Croc crossbar manager port, so the user domain needs one crossbar port instead of five.

---
 rtl/ascon_obi_mgr_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ascon_obi_mgr_arb.sv
// ascon_obi_mgr_arb: round-robin merge of the ASCON DMA managers onto one OBI manager port,
// with an ordering FIFO that steers in-order responses back. Optional macro: ASCON_ARB_PRIO_EN.
package ascon_obi_mgr_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

module ascon_obi_mgr_arb
  import ascon_obi_mgr_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 5,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned HiPrioIdx      = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                testmode_i,
  input  mgr_obi_req_t [NumReq-1:0]           req_i,
  output mgr_obi_rsp_t [NumReq-1:0]           rsp_o,
  output mgr_obi_req_t                        mgr_req_o,
  input  mgr_obi_rsp_t                        mgr_rsp_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                err_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding+1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  idx_t                       rr_q, lock_idx_q, rr_sel, cand, sel, head;
  logic                       lock_q, rr_any, any, rr_upd, full, push, pop, err_q;
  ptr_t                       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            cnt_q;
  idx_t [MaxOutstanding-1:0]  fifo_q;

  logic unused_ok;
  assign unused_ok = ^{testmode_i, 32'(HiPrioIdx)};

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding-1)) ? '0 : p + 1'b1;
  endfunction

  // Walk downwards so the last hit is the one closest to (at or after) rr_q.
  always_comb begin
    rr_sel = rr_q;
    rr_any = 1'b0;
    cand   = '0;
    for (int k = NumReq-1; k >= 0; k--) begin
      cand = idx_t'((32'(rr_q) + 32'(k)) % NumReq);
      if (req_i[cand].req) begin
        rr_any = 1'b1;
        rr_sel = cand;
      end
    end
  end

  // A stalled request keeps the port until granted, so the a-channel stays stable.
  always_comb begin
    sel = rr_sel;
    any = rr_any;
    if (lock_q) begin
      sel = lock_idx_q;
      any = req_i[lock_idx_q].req;
    end
`ifdef ASCON_ARB_PRIO_EN
    else if (req_i[HiPrioIdx].req) begin
      sel = idx_t'(HiPrioIdx);
      any = 1'b1;
    end
`endif
  end

`ifdef ASCON_ARB_PRIO_EN
  // Any grant to HiPrioIdx came from the priority path, so it leaves the rotation alone.
  assign rr_upd = (sel != idx_t'(HiPrioIdx));
`else
  assign rr_upd = 1'b1;
`endif

  assign full          = (cnt_q == CntW'(MaxOutstanding));
  assign mgr_req_o.req = any & ~full & ~rst_i;
  assign mgr_req_o.a   = req_i[sel].a;
  assign push          = mgr_req_o.req & mgr_rsp_i.gnt;
  assign pop           = mgr_rsp_i.rvalid & ~rst_i & (cnt_q != '0);
  assign head          = fifo_q[rd_ptr_q];
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  for (genvar g = 0; g < NumReq; g++) begin : g_lane
    logic hit;
    assign hit             = pop & (head == idx_t'(g));
    assign rsp_o[g].gnt    = push & (sel == idx_t'(g));
    assign rsp_o[g].rvalid = hit;
    assign rsp_o[g].r      = hit ? mgr_rsp_i.r : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fifo_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        lock_q           <= 1'b0;
        if (rr_upd) rr_q <= (sel == idx_t'(NumReq-1)) ? '0 : sel + 1'b1;
      end else if (mgr_req_o.req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push != pop) cnt_q <= push ? cnt_q + 1'b1 : cnt_q - 1'b1;
      if (mgr_rsp_i.rvalid && cnt_q == '0) err_q <= 1'b1;
    end
  end
endmodule
